// File: rtl/issue_partition_sel_pkg.sv
// Shared types for the issue-queue partition: dispatch/issue packets, stored
// entry layout, fixed field widths and the tag wakeup compare helper.
package issue_partition_sel_pkg;

  localparam int IQ_LOG   = 6;
  localparam int TAG_W    = 7;
  localparam int PIPE_LOG = 2;
  localparam int WAKE_W   = 4;

  typedef logic [TAG_W-1:0]    phys_tag_t;
  typedef logic [PIPE_LOG-1:0] pipe_t;
  typedef logic [IQ_LOG-1:0]   iq_id_t;

  typedef struct packed {
    iq_id_t    id;
    phys_tag_t src1Tag;
    logic      src1Rdy;
    phys_tag_t src2Tag;
    logic      src2Rdy;
    phys_tag_t dstTag;
    logic      dstValid;
    pipe_t     pipe;
  } iq_disp_pkt_t;

  typedef struct packed {
    iq_id_t    id;
    phys_tag_t dstTag;
    logic      dstValid;
  } iq_iss_pkt_t;

  typedef struct packed {
    phys_tag_t src1Tag;
    logic      src1Rdy;
    phys_tag_t src2Tag;
    logic      src2Rdy;
    phys_tag_t dstTag;
    logic      dstValid;
    pipe_t     pipe;
  } iq_entry_t;

  // True when any valid broadcast port carries the given tag.
  function automatic logic tagHit(input phys_tag_t tag,
                                  input logic [WAKE_W-1:0] wakeValid,
                                  input phys_tag_t [WAKE_W-1:0] wakeTag);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKE_W; w++) begin
      if (wakeValid[w] && (wakeTag[w] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/issue_partition_sel_if.sv
// Bus between the dispatch/backend side (master) and one issue-queue
// partition (slave): dispatch lanes, wakeup broadcast, pipe handshake, issue.
interface issue_partition_sel_if
  import issue_partition_sel_pkg::*;
#(
  parameter int DISP_W  = 4,
  parameter int ISSUE_W = 4,
  parameter int ENT_LOG = 4
);
  logic                           flush;
  logic [DISP_W-1:0]              dispValid;
  iq_disp_pkt_t [DISP_W-1:0]      dispPkt;
  logic [WAKE_W-1:0]              wakeValid;
  phys_tag_t [WAKE_W-1:0]         wakeTag;
  logic [ISSUE_W-1:0]             pipeReady;
  logic [ISSUE_W-1:0]             issValid;
  iq_id_t [ISSUE_W-1:0]           issId;
  logic [ISSUE_W-1:0][TAG_W:0]    issDst;
  logic [ENT_LOG:0]               validCnt;

  modport master (
    output flush, dispValid, dispPkt, wakeValid, wakeTag, pipeReady,
    input  issValid, issId, issDst, validCnt
  );

  modport slave (
    input  flush, dispValid, dispPkt, wakeValid, wakeTag, pipeReady,
    output issValid, issId, issDst, validCnt
  );
endinterface

// File: rtl/issue_partition_sel_age_matrix.sv
// iq_age_matrix: relative-age bookkeeping for one partition and an
// oldest-first pick per execute pipe. ageQ[j][i]=1 means slot j is older
// than slot i. Only built when IQ_AGE_SELECT_EN is defined.
`ifdef IQ_AGE_SELECT_EN
module iq_age_matrix #(
  parameter int ENTRIES = 16,
  parameter int ENT_LOG = 4,
  parameter int DISP_W  = 4,
  parameter int ISSUE_W = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             flush,
  input  logic [ENTRIES-1:0]               valid,
  input  logic [DISP_W-1:0]                laneWr,
  input  logic [DISP_W-1:0][ENT_LOG-1:0]   laneSlot,
  input  logic [ISSUE_W-1:0][ENTRIES-1:0]  cand,
  output logic [ISSUE_W-1:0]               pickHit,
  output logic [ISSUE_W-1:0][ENT_LOG-1:0]  pickIdx
);
  logic [ENTRIES-1:0][ENTRIES-1:0] ageQ, ageD;
  logic [DISP_W-1:0][ENTRIES-1:0]  laneMask, olderMask, newerMask;

  // Slots written by lower lanes are older than this lane's slot, higher lanes newer.
  always_comb begin
    for (int k = 0; k < DISP_W; k++) begin
      laneMask[k] = '0;
      if (laneWr[k]) laneMask[k][laneSlot[k]] = 1'b1;
    end
    for (int k = 0; k < DISP_W; k++) begin
      olderMask[k] = '0;
      newerMask[k] = '0;
      for (int m = 0; m < DISP_W; m++) begin
        if (m < k) olderMask[k] = olderMask[k] | laneMask[m];
        if (m > k) newerMask[k] = newerMask[k] | laneMask[m];
      end
    end
  end

  // A new slot is younger than everything valid; its row only marks same-cycle later lanes.
  always_comb begin
    ageD = ageQ;
    for (int k = 0; k < DISP_W; k++) begin
      if (laneWr[k]) begin
        for (int j = 0; j < ENTRIES; j++) begin
          ageD[j][laneSlot[k]] = valid[j] | olderMask[k][j];
          ageD[laneSlot[k]][j] = newerMask[k][j];
        end
      end
    end
  end

  // Oldest candidate per pipe: no other candidate in its column claims to be older.
  always_comb begin
    logic older;
    older = 1'b0;
    for (int p = 0; p < ISSUE_W; p++) begin
      pickHit[p] = |cand[p];
      pickIdx[p] = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        older = 1'b0;
        for (int j = 0; j < ENTRIES; j++) begin
          older = older | (cand[p][j] & ageQ[j][i]);
        end
        if (cand[p][i] && !older) pickIdx[p] = ENT_LOG'(i);
      end
    end
  end

  // Age matrix register, wiped by reset and flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ageQ <= '0;
    end else if (flush) begin
      ageQ <= '0;
    end else begin
      ageQ <= ageD;
    end
  end
endmodule
`endif

// File: rtl/issue_partition_sel.sv
// issue_partition_sel: one partition of the issue queue. Holds ENTRIES slots,
// wakes source operands from broadcast tags and grants one ready entry per
// execute pipe each cycle.
// Build option: IQ_AGE_SELECT_EN picks the oldest candidate per pipe through
// iq_age_matrix; when undefined the lowest slot index wins.
module issue_partition_sel
  import issue_partition_sel_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ENT_LOG = 4,
  parameter int PART_ID = 0,
  parameter int DISP_W  = 4,
  parameter int ISSUE_W = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  issue_partition_sel_if.slave bus
);
  localparam logic [IQ_LOG-ENT_LOG-1:0] PART_BITS = (IQ_LOG-ENT_LOG)'(PART_ID);

  logic [ENTRIES-1:0]              validQ;
  iq_entry_t                       entryQ [ENTRIES];
  logic [ENT_LOG:0]                cntQ, cntD;
  logic [DISP_W-1:0]               laneWr;
  logic [DISP_W-1:0][ENT_LOG-1:0]  laneSlot;
  logic [ENTRIES-1:0]              wrEn, clrEn, req;
  iq_entry_t                       wrData [ENTRIES];
  logic [ISSUE_W-1:0][ENTRIES-1:0] cand;
  logic [ISSUE_W-1:0]              pickHit, commit;
  logic [ISSUE_W-1:0][ENT_LOG-1:0] pickIdx;

  // Lanes whose id falls in this partition's slice write the slot named by the low id bits.
  always_comb begin
    for (int k = 0; k < DISP_W; k++) begin
      laneWr[k]   = bus.dispValid[k] && (bus.dispPkt[k].id[IQ_LOG-1:ENT_LOG] == PART_BITS);
      laneSlot[k] = bus.dispPkt[k].id[ENT_LOG-1:0];
    end
  end

  // Per-slot write data, with same-cycle wakeup bypass folded into the ready bits.
  always_comb begin
    iq_entry_t e;
    e    = '0;
    wrEn = '0;
    for (int i = 0; i < ENTRIES; i++) wrData[i] = '0;
    for (int k = 0; k < DISP_W; k++) begin
      if (laneWr[k]) begin
        e.src1Tag  = bus.dispPkt[k].src1Tag;
        e.src1Rdy  = bus.dispPkt[k].src1Rdy |
                     tagHit(bus.dispPkt[k].src1Tag, bus.wakeValid, bus.wakeTag);
        e.src2Tag  = bus.dispPkt[k].src2Tag;
        e.src2Rdy  = bus.dispPkt[k].src2Rdy |
                     tagHit(bus.dispPkt[k].src2Tag, bus.wakeValid, bus.wakeTag);
        e.dstTag   = bus.dispPkt[k].dstTag;
        e.dstValid = bus.dispPkt[k].dstValid;
        e.pipe     = bus.dispPkt[k].pipe;
        wrEn[laneSlot[k]]   = 1'b1;
        wrData[laneSlot[k]] = e;
      end
    end
  end

  // Requests come only from registered state; candidates are split by target pipe.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      req[i] = validQ[i] && entryQ[i].src1Rdy && entryQ[i].src2Rdy;
    end
    for (int p = 0; p < ISSUE_W; p++) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cand[p][i] = req[i] && (entryQ[i].pipe == pipe_t'(p));
      end
    end
  end

`ifdef IQ_AGE_SELECT_EN
  iq_age_matrix #(
    .ENTRIES (ENTRIES),
    .ENT_LOG (ENT_LOG),
    .DISP_W  (DISP_W),
    .ISSUE_W (ISSUE_W)
  ) uAgeMatrix (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (bus.flush),
    .valid    (validQ),
    .laneWr   (laneWr),
    .laneSlot (laneSlot),
    .cand     (cand),
    .pickHit  (pickHit),
    .pickIdx  (pickIdx)
  );
`else
  // Fixed priority: the lowest-numbered candidate slot wins each pipe.
  always_comb begin
    for (int p = 0; p < ISSUE_W; p++) begin
      pickHit[p] = 1'b0;
      pickIdx[p] = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        if (cand[p][i]) begin
          pickHit[p] = 1'b1;
          pickIdx[p] = ENT_LOG'(i);
        end
      end
    end
  end
`endif

  // Drive grants, decide which slots retire this edge and the next occupancy count.
  always_comb begin
    iq_iss_pkt_t iss;
    iss   = '0;
    clrEn = '0;
    cntD  = cntQ;
    for (int p = 0; p < ISSUE_W; p++) begin
      iss = '0;
      if (pickHit[p]) begin
        iss.id       = {PART_BITS, pickIdx[p]};
        iss.dstTag   = entryQ[pickIdx[p]].dstTag;
        iss.dstValid = entryQ[pickIdx[p]].dstValid;
      end
      bus.issValid[p] = pickHit[p];
      bus.issId[p]    = iss.id;
      bus.issDst[p]   = {iss.dstTag, iss.dstValid};
      commit[p]       = pickHit[p] && bus.pipeReady[p];
      if (commit[p]) begin
        clrEn[pickIdx[p]] = 1'b1;
        cntD = cntD - (ENT_LOG+1)'(1);
      end
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (wrEn[i]) cntD = cntD + (ENT_LOG+1)'(1);
    end
  end

  assign bus.validCnt = cntQ;

  // Slot state: flush beats dispatch and grant; wakeups only ever set ready bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      validQ <= '0;
      cntQ   <= '0;
      for (int i = 0; i < ENTRIES; i++) entryQ[i] <= '0;
    end else if (bus.flush) begin
      validQ <= '0;
      cntQ   <= '0;
      for (int i = 0; i < ENTRIES; i++) entryQ[i] <= '0;
    end else begin
      cntQ <= cntD;
      for (int i = 0; i < ENTRIES; i++) begin
        if (wrEn[i]) begin
          validQ[i] <= 1'b1;
          entryQ[i] <= wrData[i];
        end else if (validQ[i]) begin
          if (clrEn[i]) validQ[i] <= 1'b0;
          if (tagHit(entryQ[i].src1Tag, bus.wakeValid, bus.wakeTag)) entryQ[i].src1Rdy <= 1'b1;
          if (tagHit(entryQ[i].src2Tag, bus.wakeValid, bus.wakeTag)) entryQ[i].src2Rdy <= 1'b1;
        end
      end
    end
  end

  // Dispatch may only target free slots; occupancy can never exceed the slot count.
  assert property (@(posedge clk) disable iff (!reset_n || bus.flush) ((wrEn & validQ) == '0));
  assert property (@(posedge clk) disable iff (!reset_n) (cntQ <= (ENT_LOG+1)'(ENTRIES)));

endmodule

// File: tb/tb_issue_partition_sel.sv
// Testbench for issue_partition_sel (PART_ID 0): directed dispatch/wakeup/grant
// vectors; expected grants go into a scoreboard queue that a negedge monitor
// drains whenever a grant is committed.
module tb_issue_partition_sel;
  import issue_partition_sel_pkg::*;

  typedef struct {
    int                pipe;
    logic [IQ_LOG-1:0] id;
    logic [TAG_W:0]    dst;
  } exp_t;

`ifdef IQ_AGE_SELECT_EN
  localparam bit AGE_EN = 1'b1;
`else
  localparam bit AGE_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   tests;
  int   failures;
  exp_t expQ[$];

  issue_partition_sel_if bus();

  issue_partition_sel dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    tests++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
    end
  endtask

  // Put one instruction on a dispatch lane for the coming edge.
  task automatic applyStimulus(input int lane, input logic [IQ_LOG-1:0] id,
                               input logic [TAG_W-1:0] s1t, input logic s1r,
                               input logic [TAG_W-1:0] s2t, input logic s2r,
                               input logic [TAG_W-1:0] dt, input logic dv, input int pipe);
    bus.dispValid[lane]        = 1'b1;
    bus.dispPkt[lane].id       = id;
    bus.dispPkt[lane].src1Tag  = s1t;
    bus.dispPkt[lane].src1Rdy  = s1r;
    bus.dispPkt[lane].src2Tag  = s2t;
    bus.dispPkt[lane].src2Rdy  = s2r;
    bus.dispPkt[lane].dstTag   = dt;
    bus.dispPkt[lane].dstValid = dv;
    bus.dispPkt[lane].pipe     = pipe_t'(pipe);
  endtask

  task automatic expectGrant(input int pipe, input logic [IQ_LOG-1:0] id,
                             input logic [TAG_W-1:0] dt, input logic dv);
    exp_t e;
    e.pipe = pipe;
    e.id   = id;
    e.dst  = {dt, dv};
    expQ.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.dispValid = '0;
    bus.wakeValid = '0;
    bus.flush     = 1'b0;
  endtask

  // Monitor: every committed grant must match the oldest expectation for its pipe.
  initial begin
    int found;
    forever begin
      @(negedge clk);
      if (reset_n && !bus.flush) begin
        for (int p = 0; p < 4; p++) begin
          if (bus.issValid[p] && bus.pipeReady[p]) begin
            found = -1;
            for (int q = 0; q < expQ.size(); q++) begin
              if (found < 0 && expQ[q].pipe == p) found = q;
            end
            if (found < 0) begin
              tests++;
              failures++;
              $display("[TB] FAIL unexpected grant pipe %0d: got id 0x%0h, required no grant", p, bus.issId[p]);
            end else begin
              checkOutput($sformatf("grant id pipe %0d", p), 32'(bus.issId[p]), 32'(expQ[found].id));
              checkOutput($sformatf("grant dst pipe %0d", p), 32'(bus.issDst[p]), 32'(expQ[found].dst));
              expQ.delete(found);
            end
          end
        end
      end
    end
  end

  initial begin
    tests     = 0;
    failures  = 0;
    reset_n   = 1'b0;
    bus.flush     = 1'b0;
    bus.dispValid = '0;
    bus.dispPkt   = '0;
    bus.wakeValid = '0;
    bus.wakeTag   = '0;
    bus.pipeReady = '0;
    #12;
    checkOutput("reset issValid", 32'(bus.issValid), 32'h0);
    checkOutput("reset issId", 32'(bus.issId), 32'h0);
    checkOutput("reset issDst", 32'(bus.issDst), 32'h0);
    checkOutput("reset validCnt", 32'(bus.validCnt), 32'h0);
    reset_n = 1'b1;
    bus.pipeReady = 4'hF;

    // Basic dispatch of slot 3 to pipe 2, granted the next cycle and freed.
    applyStimulus(0, 6'd3, 7'h01, 1'b1, 7'h02, 1'b1, 7'h10, 1'b1, 2);
    expectGrant(2, 6'd3, 7'h10, 1'b1);
    step();
    checkOutput("basic issValid", 32'(bus.issValid), 32'h4);
    checkOutput("basic issId[2]", 32'(bus.issId[2]), 32'd3);
    checkOutput("basic cnt 1", 32'(bus.validCnt), 32'd1);
    step();
    checkOutput("basic cnt 0", 32'(bus.validCnt), 32'd0);
    checkOutput("basic issValid idle", 32'(bus.issValid), 32'h0);

    // Simultaneous write and committed grant keep the count exact.
    applyStimulus(0, 6'd3, 7'h01, 1'b1, 7'h02, 1'b1, 7'h11, 1'b0, 2);
    expectGrant(2, 6'd3, 7'h11, 1'b0);
    step();
    applyStimulus(1, 6'd6, 7'h01, 1'b1, 7'h02, 1'b1, 7'h12, 1'b1, 2);
    expectGrant(2, 6'd6, 7'h12, 1'b1);
    step();
    checkOutput("write+grant cnt", 32'(bus.validCnt), 32'd1);
    checkOutput("write+grant issId[2]", 32'(bus.issId[2]), 32'd6);
    step();
    checkOutput("write+grant cnt drained", 32'(bus.validCnt), 32'd0);

    // Wakeup: src1 0x25 not ready until broadcast; request appears the cycle after the wake.
    applyStimulus(0, 6'd5, 7'h25, 1'b0, 7'h03, 1'b1, 7'h13, 1'b1, 1);
    expectGrant(1, 6'd5, 7'h13, 1'b1);
    step();
    checkOutput("wake before issValid[1]", 32'(bus.issValid[1]), 32'd0);
    step();
    checkOutput("wake still waiting", 32'(bus.issValid[1]), 32'd0);
    bus.wakeValid[2] = 1'b1;
    bus.wakeTag[2]   = 7'h25;
    #2;
    checkOutput("wake cycle no request", 32'(bus.issValid[1]), 32'd0);
    step();
    checkOutput("wake after issValid[1]", 32'(bus.issValid[1]), 32'd1);
    checkOutput("wake after issId[1]", 32'(bus.issId[1]), 32'd5);
    step();

    // Same-cycle bypass: wake in the dispatch cycle grants right after the write.
    bus.wakeValid[0] = 1'b1;
    bus.wakeTag[0]   = 7'h30;
    applyStimulus(1, 6'd7, 7'h04, 1'b1, 7'h30, 1'b0, 7'h14, 1'b1, 3);
    expectGrant(3, 6'd7, 7'h14, 1'b1);
    step();
    checkOutput("bypass issValid[3]", 32'(bus.issValid[3]), 32'd1);
    checkOutput("bypass issId[3]", 32'(bus.issId[3]), 32'd7);
    step();

    // A matching tag on an invalid wake port must not wake.
    applyStimulus(0, 6'd8, 7'h40, 1'b0, 7'h05, 1'b1, 7'h15, 1'b0, 0);
    expectGrant(0, 6'd8, 7'h15, 1'b0);
    step();
    bus.wakeTag[1] = 7'h40;
    step();
    checkOutput("invalid wake port", 32'(bus.issValid[0]), 32'd0);
    bus.wakeValid[3] = 1'b1;
    bus.wakeTag[3]   = 7'h40;
    step();
    checkOutput("port3 wake issId[0]", 32'(bus.issId[0]), 32'd8);
    step();

    // Backpressure: pipe 1 stalled three cycles, grant held, then a single commit.
    bus.pipeReady[1] = 1'b0;
    applyStimulus(2, 6'd10, 7'h06, 1'b1, 7'h07, 1'b1, 7'h22, 1'b1, 1);
    expectGrant(1, 6'd10, 7'h22, 1'b1);
    step();
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("stall %0d issValid[1]", c), 32'(bus.issValid[1]), 32'd1);
      checkOutput($sformatf("stall %0d issId[1]", c), 32'(bus.issId[1]), 32'd10);
      checkOutput($sformatf("stall %0d cnt", c), 32'(bus.validCnt), 32'd1);
      step();
    end
    bus.pipeReady[1] = 1'b1;
    checkOutput("stall release issId[1]", 32'(bus.issId[1]), 32'd10);
    step();
    checkOutput("stall commit cnt", 32'(bus.validCnt), 32'd0);
    checkOutput("stall commit issValid[1]", 32'(bus.issValid[1]), 32'd0);

    // Selection order: slot 9 written before slot 2, then lanes 0/1 in one cycle.
    bus.pipeReady[0] = 1'b0;
    applyStimulus(0, 6'd9, 7'h08, 1'b1, 7'h09, 1'b1, 7'h31, 1'b1, 0);
    step();
    applyStimulus(0, 6'd2, 7'h08, 1'b1, 7'h09, 1'b1, 7'h32, 1'b1, 0);
    step();
    if (AGE_EN) begin
      expectGrant(0, 6'd9, 7'h31, 1'b1);
      expectGrant(0, 6'd2, 7'h32, 1'b1);
    end else begin
      expectGrant(0, 6'd2, 7'h32, 1'b1);
      expectGrant(0, 6'd9, 7'h31, 1'b1);
    end
    checkOutput("order first issId[0]", 32'(bus.issId[0]), AGE_EN ? 32'd9 : 32'd2);
    bus.pipeReady[0] = 1'b1;
    step();
    checkOutput("order second issId[0]", 32'(bus.issId[0]), AGE_EN ? 32'd2 : 32'd9);
    step();
    bus.pipeReady[0] = 1'b0;
    applyStimulus(0, 6'd12, 7'h08, 1'b1, 7'h09, 1'b1, 7'h33, 1'b0, 0);
    applyStimulus(1, 6'd4,  7'h08, 1'b1, 7'h09, 1'b1, 7'h34, 1'b0, 0);
    step();
    if (AGE_EN) begin
      expectGrant(0, 6'd12, 7'h33, 1'b0);
      expectGrant(0, 6'd4,  7'h34, 1'b0);
    end else begin
      expectGrant(0, 6'd4,  7'h34, 1'b0);
      expectGrant(0, 6'd12, 7'h33, 1'b0);
    end
    checkOutput("lanes first issId[0]", 32'(bus.issId[0]), AGE_EN ? 32'd12 : 32'd4);
    bus.pipeReady[0] = 1'b1;
    step();
    step();
    checkOutput("order drained cnt", 32'(bus.validCnt), 32'd0);

    // Fill all 16 slots with grants stalled, then flush with dispatches pending.
    bus.pipeReady = 4'h0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) begin
        applyStimulus(k, 6'(c * 4 + k), 7'h0A, 1'b1, 7'h0B, 1'b1, 7'h40, 1'b1, k);
      end
      step();
    end
    checkOutput("full cnt", 32'(bus.validCnt), 32'd16);
    checkOutput("full issValid", 32'(bus.issValid), 32'hF);
    bus.pipeReady = 4'hF;
    bus.flush     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(k, 6'(k), 7'h0A, 1'b1, 7'h0B, 1'b1, 7'h41, 1'b1, k);
    end
    step();
    checkOutput("flush cnt", 32'(bus.validCnt), 32'd0);
    checkOutput("flush issValid", 32'(bus.issValid), 32'h0);
    step();
    checkOutput("post flush issValid", 32'(bus.issValid), 32'h0);

    // Asynchronous reset mid-cycle, then a foreign-partition id is ignored.
    bus.pipeReady = 4'h0;
    applyStimulus(0, 6'd1, 7'h0A, 1'b1, 7'h0B, 1'b1, 7'h42, 1'b1, 0);
    step();
    checkOutput("pre reset issValid[0]", 32'(bus.issValid[0]), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset issValid", 32'(bus.issValid), 32'h0);
    checkOutput("async reset issId", 32'(bus.issId), 32'h0);
    checkOutput("async reset cnt", 32'(bus.validCnt), 32'd0);
    #1;
    reset_n = 1'b1;
    step();
    checkOutput("after reset issValid", 32'(bus.issValid), 32'h0);
    applyStimulus(0, 6'h13, 7'h0A, 1'b1, 7'h0B, 1'b1, 7'h43, 1'b1, 0);
    step();
    checkOutput("foreign id cnt", 32'(bus.validCnt), 32'd0);
    checkOutput("foreign id issValid", 32'(bus.issValid), 32'h0);
    bus.pipeReady = 4'hF;
    step();
    step();
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
